// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_W    = 2 * INSTR_W;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      DISCARD
   } fetch_state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: EX redirect, IF->ID buffer handshake and instruction-memory port.
interface fetch_if;
   import fetch_pkg::*;

   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic               id_ready;
   logic               fetch_valid;
   logic [PC_W-1:0]    pc_out;
   logic [INSTR_W-1:0] instr_out;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      input  redirect_valid, redirect_pc, id_ready, imem_gnt, imem_rvalid, imem_rdata,
      output fetch_valid, pc_out, instr_out, imem_req, imem_addr
   );

   modport slave (
      output redirect_valid, redirect_pc, id_ready, imem_gnt, imem_rvalid, imem_rdata,
      input  fetch_valid, pc_out, instr_out, imem_req, imem_addr
   );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a flush port.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  fetch_entry_t     wdata,
   output fetch_entry_t     head,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, redirect handling
// and a fetch queue feeding the IF->ID buffer.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned  N          = INSTR_W,
   parameter logic [2*N-1:0] RESET_PC = '0,
   parameter int unsigned  FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   fetch_if.master bus
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]  req_pc_q, req_pc_d;
   logic             push, pop, clear;
   logic             outstanding, credit, req;
   logic             empty;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     wdata;

   // Credit covers queued entries plus the one in flight, so the queue never overflows.
   assign outstanding = (state_q != REQ);
   assign credit      = (32'(count) + 32'(outstanding)) < FIFO_DEPTH;
   assign req         = rst_n && (state_q == REQ) && credit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= REQ;
         fetch_pc_q <= PC_W'(RESET_PC);
         req_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      case (state_q)
         REQ: begin
            if (req && bus.imem_gnt) begin
               state_d    = bus.redirect_valid ? DISCARD : WAIT;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_STEP;
            end
         end
         WAIT: begin
            if (bus.imem_rvalid) begin
               state_d = REQ;
               push    = !bus.redirect_valid;
            end else if (bus.redirect_valid) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (bus.imem_rvalid) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
      // A redirect wins over the sequential increment.
      if (bus.redirect_valid) fetch_pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
   end

   assign clear = bus.redirect_valid;
   assign pop   = !empty && bus.id_ready && !bus.redirect_valid;
   assign wdata = '{pc: req_pc_q, instr: bus.imem_rdata};

   fetch_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .wdata (wdata),
      .head  (head),
      .empty (empty),
      .count (count)
   );

   assign bus.fetch_valid = !empty;
   assign bus.pc_out      = head.pc;
   assign bus.instr_out   = head.instr;
   assign bus.imem_req    = req;
   assign bus.imem_addr   = rst_n ? fetch_pc_q : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder model plus an in-order scoreboard.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [PC_W-1:0] RST_PC = 64'h1000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetch_if bus ();

   fetch_unit #(.N(INSTR_W), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int              vectors = 0;
   int              errors  = 0;
   fetch_entry_t    sb[$];
   logic [PC_W-1:0] pop_log[$];
   int              pops = 0;
   logic [PC_W-1:0] exp_pc = RST_PC;
   bit              pend = 1'b0;
   bit              pend_stale = 1'b0;
   int              pend_cnt = 0;
   logic [PC_W-1:0] pend_pc = '0;
   bit              gnt_en = 1'b1;
   int              lat = 1;

   function automatic logic [INSTR_W-1:0] data_of(input logic [PC_W-1:0] pc);
      return pc[INSTR_W-1:0] ^ {pc[15:0], pc[31:16]} ^ 32'hC0DE_0000 ^ pc[PC_W-1:INSTR_W];
   endfunction

   // One clock: inputs already set at negedge; check outputs, drive the memory, advance.
   task automatic tick();
      fetch_entry_t e;
      #1;
      if (!rst_n) begin
         vectors++;
         if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.pc_out !== '0 ||
             bus.instr_out !== '0 || bus.imem_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b req=%b pc=%h instr=%h addr=%h, all must be 0",
                     bus.fetch_valid, bus.imem_req, bus.pc_out, bus.instr_out, bus.imem_addr);
         end
         sb.delete();
      end else begin
         vectors++;
         if (bus.fetch_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL fetch_valid got %b exp %b", bus.fetch_valid, sb.size() != 0);
         end
         if (bus.fetch_valid === 1'b1 && sb.size() != 0) begin
            vectors++;
            if (bus.pc_out !== sb[0].pc || bus.instr_out !== sb[0].instr) begin
               errors++;
               $display("FAIL head got pc=%h instr=%h exp pc=%h instr=%h",
                        bus.pc_out, bus.instr_out, sb[0].pc, sb[0].instr);
            end
            if (bus.id_ready && !bus.redirect_valid) begin
               void'(sb.pop_front());
               pops++;
               pop_log.push_back(bus.pc_out);
            end
         end else if (bus.fetch_valid === 1'b0) begin
            vectors++;
            if (bus.pc_out !== '0 || bus.instr_out !== '0) begin
               errors++;
               $display("FAIL empty_head got pc=%h instr=%h exp 0", bus.pc_out, bus.instr_out);
            end
         end
         if (bus.redirect_valid) sb.delete();
      end
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      if (!rst_n) begin
         exp_pc     = RST_PC;
         pend_stale = 1'b1;
      end
      if (pend) begin
         if (bus.redirect_valid) pend_stale = 1'b1;
         if (pend_cnt > 0) pend_cnt--;
         if (pend_cnt == 0 && rst_n) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = data_of(pend_pc);
            if (!pend_stale) begin
               e = '{pc: pend_pc, instr: data_of(pend_pc)};
               sb.push_back(e);
            end
            pend = 1'b0;
         end
      end else if (rst_n && bus.imem_req === 1'b1 && gnt_en) begin
         vectors++;
         if (bus.imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL grant_addr got %h exp %h", bus.imem_addr, exp_pc);
         end
         bus.imem_gnt = 1'b1;
         pend       = 1'b1;
         pend_cnt   = lat;
         pend_pc    = exp_pc;
         pend_stale = bus.redirect_valid;
         exp_pc     = exp_pc + 64'd4;
      end
      if (rst_n && bus.redirect_valid) exp_pc = {bus.redirect_pc[PC_W-1:2], 2'b00};
      @(negedge clk);
   endtask

   task automatic wait_pops(input int want, input string name);
      int k = 0;
      while (pop_log.size() < want && k < 60) begin
         tick();
         k++;
      end
      vectors++;
      if (pop_log.size() < want) begin
         errors++;
         $display("FAIL %s_timeout got %0d pops exp %0d", name, pop_log.size(), want);
      end
   endtask

   task automatic redirect_to(input logic [PC_W-1:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = target;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   task automatic check_first_pop(input int n0, input logic [PC_W-1:0] exp, input string name);
      wait_pops(n0 + 1, name);
      if (pop_log.size() > n0) begin
         vectors++;
         if (pop_log[n0] !== exp) begin
            errors++;
            $display("FAIL %s_pc got %h exp %h", name, pop_log[n0], exp);
         end
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_wait req=%b valid=%b exp 0 0", bus.imem_req, bus.fetch_valid);
      end
   endtask

   task automatic test_stream();
      int n0 = pop_log.size();
      int p0;
      repeat (12) tick();
      wait_pops(n0 + 3, "stream");
      for (int i = 0; i < 3; i++) begin
         if (pop_log.size() > n0 + i) begin
            vectors++;
            if (pop_log[n0+i] !== RST_PC + 64'(4 * i)) begin
               errors++;
               $display("FAIL stream_pc%0d got %h exp %h", i, pop_log[n0+i], RST_PC + 64'(4 * i));
            end
         end
      end
      p0 = pops;
      repeat (20) tick();
      vectors++;
      if (pops - p0 != 10) begin
         errors++;
         $display("FAIL throughput got %0d pops in 20 cycles exp 10", pops - p0);
      end
   endtask

   task automatic test_backpressure();
      int p0;
      bus.id_ready = 1'b0;
      repeat (10) tick();
      vectors++;
      if (bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_stall req=%b valid=%b exp 0 1", bus.imem_req, bus.fetch_valid);
      end
      gnt_en = 1'b0;
      bus.id_ready = 1'b1;
      p0 = pops;
      repeat (6) begin
         tick();
         vectors++;
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL gnt_stall req=%b addr=%h exp 1 %h", bus.imem_req, bus.imem_addr, exp_pc);
         end
      end
      vectors++;
      if (pops - p0 != 2) begin
         errors++;
         $display("FAIL drain_count got %0d exp 2", pops - p0);
      end
      gnt_en = 1'b1;
      p0 = pops;
      repeat (8) tick();
      vectors++;
      if (pops - p0 < 2) begin
         errors++;
         $display("FAIL resume got %0d pops exp >=2", pops - p0);
      end
   endtask

   task automatic test_redirect_wait();
      int k = 0;
      lat = 3;
      bus.id_ready = 1'b0;
      repeat (14) tick();
      bus.id_ready = 1'b1;
      tick();
      bus.id_ready = 1'b0;
      while (!(pend && pend_cnt == lat) && k < 30) begin
         tick();
         k++;
      end
      vectors++;
      if (!(pend && pend_cnt == lat)) begin
         errors++;
         $display("FAIL wait_state_timeout got pend=%0d exp 1", pend);
      end
      redirect_to(64'h2002);
      vectors++;
      if (bus.fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty got valid=%b exp 0", bus.fetch_valid);
      end
      bus.id_ready = 1'b1;
      check_first_pop(pop_log.size(), 64'h2000, "redir_wait");
   endtask

   task automatic test_redirect_gnt();
      int k = 0;
      lat = 1;
      while (!(!pend && bus.imem_req === 1'b1) && k < 30) begin
         tick();
         k++;
      end
      redirect_to(64'h3001);
      check_first_pop(pop_log.size(), 64'h3000, "redir_gnt");
   endtask

   task automatic test_redirect_rvalid();
      int k = 0;
      lat = 2;
      while (!(pend && pend_cnt == 1) && k < 30) begin
         tick();
         k++;
      end
      redirect_to(64'h4008);
      check_first_pop(pop_log.size(), 64'h4008, "redir_rvalid");
   endtask

   task automatic test_wrap();
      int n0;
      lat = 1;
      redirect_to(64'hFFFF_FFFF_FFFF_FFFE);
      n0 = pop_log.size();
      check_first_pop(n0, 64'hFFFF_FFFF_FFFF_FFFC, "wrap_top");
      check_first_pop(n0 + 1, 64'h0, "wrap_zero");
   endtask

   task automatic test_reset_mid();
      int k = 0;
      lat = 3;
      while (!(pend && pend_cnt == lat) && k < 30) begin
         tick();
         k++;
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.fetch_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.imem_addr !== '0 ||
          bus.pc_out !== '0 || bus.instr_out !== '0) begin
         errors++;
         $display("FAIL mid_reset valid=%b req=%b addr=%h pc=%h, all must be 0",
                  bus.fetch_valid, bus.imem_req, bus.imem_addr, bus.pc_out);
      end
      tick();
      rst_n = 1'b1;
      check_first_pop(pop_log.size(), RST_PC, "post_reset");
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_gnt();
      test_redirect_rvalid();
      test_wrap();
      test_reset_mid();
      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
